// File: rtl/p4_router_pkg.sv
// Shared constants, metadata layout and FSM encoding for the P4 router egress path.
package p4_router_pkg;

  localparam int META_WIDTH    = 19;
  localparam int META_DROP_BIT = 0;
  localparam int META_PORT_LSB = 1;
  localparam int META_PORT_W   = 4;

  // Field order matches the bit positions above (drop at bit 0, port at 4:1).
  typedef struct packed {
    logic [META_WIDTH-META_PORT_W-2:0] rsvd;
    logic [META_PORT_W-1:0]            egress_port;
    logic                              drop;
  } p4_meta_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    DROP = 2'd2
  } egress_state_t;

  // Saturating increment for the 32-bit packet counters.
  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/p4_meta_fifo.sv
// Single-clock register FIFO holding per-packet routing metadata.
// A push while full is only accepted when a pop happens in the same cycle.
module p4_meta_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign overflow = push && full && !do_pop;
  assign head     = mem[rd_ptr[AW-1:0]];

  // Pointer update; the extra MSB distinguishes full from empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage array; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/p4_egress_demux.sv
// Steers each router output packet to one egress AXI-Stream port or drops it,
// pairing packets in order with metadata queued in p4_meta_fifo.
//
//   state | meaning
//   IDLE  | no packet open; waits for queued metadata and data_in_tvalid
//   FWD   | packet passes combinationally to data_out[sel]
//   DROP  | packet is accepted and discarded
module p4_egress_demux
  import p4_router_pkg::*;
#(
  parameter int NUM_PORTS       = 4,
  parameter int DATA_BYTES      = 8,
  parameter int META_FIFO_DEPTH = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [META_WIDTH-1:0]                 meta_in,
  input  logic                                  meta_in_valid,
  input  logic [DATA_BYTES*8-1:0]               data_in_tdata,
  input  logic [DATA_BYTES-1:0]                 data_in_tkeep,
  input  logic                                  data_in_tlast,
  input  logic                                  data_in_tvalid,
  output logic                                  data_in_tready,
  output logic [NUM_PORTS-1:0][DATA_BYTES*8-1:0] data_out_tdata,
  output logic [NUM_PORTS-1:0][DATA_BYTES-1:0]   data_out_tkeep,
  output logic [NUM_PORTS-1:0]                  data_out_tlast,
  output logic [NUM_PORTS-1:0]                  data_out_tvalid,
  input  logic [NUM_PORTS-1:0]                  data_out_tready,
  output logic [31:0]                           drop_count,
  output logic [31:0]                           fwd_count,
  output logic                                  meta_overflow
);

  localparam int ENTRY_W = META_PORT_W + 1;
  localparam logic [META_PORT_W:0] PORT_LIMIT = (META_PORT_W+1)'(NUM_PORTS);

  egress_state_t           state;
  egress_state_t           state_next;
  logic [META_PORT_W-1:0]  sel;
  logic [ENTRY_W-1:0]      fifo_wdata;
  logic [ENTRY_W-1:0]      fifo_head;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    fifo_overflow;
  logic                    pop;
  logic                    fwd_done;
  logic                    drop_done;
  logic                    ready_sel;
  logic                    head_drop;
  logic [META_PORT_W-1:0]  head_port;

  // Only the routing fields are queued; reserved metadata bits are ignored.
  assign fifo_wdata = {meta_in[META_PORT_LSB +: META_PORT_W], meta_in[META_DROP_BIT]};
  assign head_drop  = fifo_head[0];
  assign head_port  = fifo_head[ENTRY_W-1:1];

  p4_meta_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (META_FIFO_DEPTH)
  ) u_meta_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (meta_in_valid),
    .wdata    (fifo_wdata),
    .pop      (pop),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .overflow (fifo_overflow)
  );

  // Payload fans out to every port; only the selected port's tvalid is raised.
  assign data_out_tdata = {NUM_PORTS{data_in_tdata}};
  assign data_out_tkeep = {NUM_PORTS{data_in_tkeep}};
  assign data_out_tlast = {NUM_PORTS{data_in_tlast}};

  // State register and the port select latched on the IDLE decision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sel   <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE) sel <= head_port;
    end
  end

  // Next-state, handshake and demux steering.
  always_comb begin
    state_next      = state;
    data_in_tready  = 1'b0;
    data_out_tvalid = '0;
    ready_sel       = 1'b0;
    pop             = 1'b0;
    fwd_done        = 1'b0;
    drop_done       = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty && data_in_tvalid) begin
          if (head_drop || ({1'b0, head_port} >= PORT_LIMIT)) state_next = DROP;
          else                                                 state_next = FWD;
        end
      end
      FWD: begin
        for (int p = 0; p < NUM_PORTS; p++) begin
          if (sel == META_PORT_W'(p)) begin
            ready_sel          = data_out_tready[p];
            data_out_tvalid[p] = data_in_tvalid;
          end
        end
        data_in_tready = ready_sel;
        if (data_in_tvalid && ready_sel && data_in_tlast) begin
          pop        = 1'b1;
          fwd_done   = 1'b1;
          state_next = IDLE;
        end
      end
      DROP: begin
        data_in_tready = 1'b1;
        if (data_in_tvalid && data_in_tlast) begin
          pop        = 1'b1;
          drop_done  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Saturating packet counters and sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_count     <= '0;
      drop_count    <= '0;
      meta_overflow <= 1'b0;
    end else begin
      if (fwd_done)      fwd_count     <= sat_inc(fwd_count);
      if (drop_done)     drop_count    <= sat_inc(drop_count);
      if (fifo_overflow) meta_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_p4_egress_demux.sv
// Directed bench for p4_egress_demux with NUM_PORTS=4, DATA_BYTES=8, FIFO depth 8.
module tb_p4_egress_demux;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [18:0]           meta_in;
  logic                  meta_in_valid;
  logic [63:0]           data_in_tdata;
  logic [7:0]            data_in_tkeep;
  logic                  data_in_tlast;
  logic                  data_in_tvalid;
  logic                  data_in_tready;
  logic [3:0][63:0]      data_out_tdata;
  logic [3:0][7:0]       data_out_tkeep;
  logic [3:0]            data_out_tlast;
  logic [3:0]            data_out_tvalid;
  logic [3:0]            data_out_tready;
  logic [31:0]           drop_count;
  logic [31:0]           fwd_count;
  logic                  meta_overflow;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  p4_egress_demux #(
    .NUM_PORTS       (4),
    .DATA_BYTES      (8),
    .META_FIFO_DEPTH (8)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .meta_in         (meta_in),
    .meta_in_valid   (meta_in_valid),
    .data_in_tdata   (data_in_tdata),
    .data_in_tkeep   (data_in_tkeep),
    .data_in_tlast   (data_in_tlast),
    .data_in_tvalid  (data_in_tvalid),
    .data_in_tready  (data_in_tready),
    .data_out_tdata  (data_out_tdata),
    .data_out_tkeep  (data_out_tkeep),
    .data_out_tlast  (data_out_tlast),
    .data_out_tvalid (data_out_tvalid),
    .data_out_tready (data_out_tready),
    .drop_count      (drop_count),
    .fwd_count       (fwd_count),
    .meta_overflow   (meta_overflow)
  );

  function automatic logic [63:0] beat_data(input logic [7:0] tag, input int i);
    return {tag, 48'h0, 8'(i)};
  endfunction

  function automatic logic [7:0] beat_keep(input int i, input int n);
    return (i == n - 1) ? 8'h0F : 8'hFF;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_meta(input logic drop, input logic [3:0] port);
    meta_in       = {14'h2AAA, port, drop};
    meta_in_valid = 1'b1;
    tick();
    meta_in_valid = 1'b0;
  endtask

  task automatic set_beat(input logic [7:0] tag, input int i, input int n);
    data_in_tdata  = beat_data(tag, i);
    data_in_tkeep  = beat_keep(i, n);
    data_in_tlast  = (i == n - 1);
    data_in_tvalid = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; meta_in = '0; meta_in_valid = 1'b0;
    data_in_tdata = '0; data_in_tkeep = '0; data_in_tlast = 1'b0; data_in_tvalid = 1'b0;
    data_out_tready = 4'hF;
    tick(); tick();
    n_checks++; if (data_in_tready !== 1'b0) begin n_fail++; $display("FAIL reset_tready: got %b want 0", data_in_tready); end
    n_checks++; if (data_out_tvalid !== 4'b0) begin n_fail++; $display("FAIL reset_tvalid: got %b want 0000", data_out_tvalid); end
    n_checks++; if (fwd_count !== 32'd0 || drop_count !== 32'd0) begin n_fail++; $display("FAIL reset_counts: got fwd=%0d drop=%0d want 0/0", fwd_count, drop_count); end
    n_checks++; if (meta_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", meta_overflow); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_forward();
    send_meta(1'b0, 4'd2);
    set_beat(8'hA2, 0, 4);
    #1;
    n_checks++; if (data_in_tready !== 1'b0 || data_out_tvalid !== 4'b0) begin n_fail++; $display("FAIL fwd_idle: got tready=%b tvalid=%b want 0/0000", data_in_tready, data_out_tvalid); end
    tick();
    for (int i = 0; i < 4; i++) begin
      set_beat(8'hA2, i, 4);
      #1;
      n_checks++; if (data_out_tvalid !== 4'b0100 || data_in_tready !== 1'b1) begin n_fail++; $display("FAIL fwd_valid beat %0d: got tvalid=%b tready=%b want 0100/1", i, data_out_tvalid, data_in_tready); end
      n_checks++; if (data_out_tdata[2] !== beat_data(8'hA2, i) || data_out_tkeep[2] !== beat_keep(i, 4) || data_out_tlast[2] !== (i == 3)) begin
        n_fail++; $display("FAIL fwd_payload beat %0d: got %h/%h/%b want %h/%h/%b", i, data_out_tdata[2], data_out_tkeep[2], data_out_tlast[2], beat_data(8'hA2, i), beat_keep(i, 4), (i == 3));
      end
      tick();
    end
    data_in_tvalid = 1'b0;
    n_checks++; if (fwd_count !== 32'd1) begin n_fail++; $display("FAIL fwd_count: got %0d want 1", fwd_count); end
    // With the FIFO empty, valid data must not start a packet.
    set_beat(8'hEE, 0, 1);
    tick(); tick();
    n_checks++; if (data_in_tready !== 1'b0 || data_out_tvalid !== 4'b0) begin n_fail++; $display("FAIL fwd_fifo_empty: got tready=%b tvalid=%b want 0/0000", data_in_tready, data_out_tvalid); end
    data_in_tvalid = 1'b0;
    tick();
  endtask

  task automatic test_drop();
    for (int k = 0; k < 2; k++) begin
      if (k == 0) send_meta(1'b1, 4'd1);
      else        send_meta(1'b0, 4'd7);
      set_beat(8'hD0, 0, 3);
      tick();
      for (int i = 0; i < 3; i++) begin
        set_beat(8'hD0, i, 3);
        #1;
        n_checks++; if (data_in_tready !== 1'b1 || data_out_tvalid !== 4'b0) begin n_fail++; $display("FAIL drop%0d beat %0d: got tready=%b tvalid=%b want 1/0000", k, i, data_in_tready, data_out_tvalid); end
        tick();
      end
      data_in_tvalid = 1'b0;
      n_checks++; if (drop_count !== 32'(k + 1) || fwd_count !== 32'd1) begin n_fail++; $display("FAIL drop%0d_count: got drop=%0d fwd=%0d want %0d/1", k, drop_count, fwd_count, k + 1); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] ports [3];
    ports[0] = 4'd0; ports[1] = 4'd1; ports[2] = 4'd3;
    for (int k = 0; k < 3; k++) send_meta(1'b0, ports[k]);
    for (int k = 0; k < 3; k++) begin
      set_beat(8'hB0 + 8'(k), 0, 2);
      #1;
      n_checks++; if (data_out_tvalid !== 4'b0 || data_in_tready !== 1'b0) begin n_fail++; $display("FAIL b2b_gap pkt %0d: got tvalid=%b tready=%b want 0000/0", k, data_out_tvalid, data_in_tready); end
      tick();
      for (int i = 0; i < 2; i++) begin
        set_beat(8'hB0 + 8'(k), i, 2);
        #1;
        n_checks++; if (data_out_tvalid !== (4'b1 << ports[k]) || data_out_tdata[ports[k]] !== beat_data(8'hB0 + 8'(k), i)) begin
          n_fail++; $display("FAIL b2b_route pkt %0d beat %0d: got tvalid=%b data=%h want %b/%h", k, i, data_out_tvalid, data_out_tdata[ports[k]], 4'b1 << ports[k], beat_data(8'hB0 + 8'(k), i));
        end
        tick();
      end
    end
    data_in_tvalid = 1'b0;
    n_checks++; if (fwd_count !== 32'd4) begin n_fail++; $display("FAIL b2b_count: got %0d want 4", fwd_count); end
    tick();
  endtask

  task automatic test_backpressure();
    int idx = 0;
    int cycles = 0;
    logic rdy;
    send_meta(1'b0, 4'd1);
    set_beat(8'hC1, 0, 10);
    tick();
    while (idx < 10 && cycles < 200) begin
      rdy = 1'($urandom_range(0, 1));
      data_out_tready = {2'b11, rdy, 1'b1};
      set_beat(8'hC1, idx, 10);
      #1;
      n_checks++; if (data_out_tvalid !== 4'b0010 || data_out_tdata[1] !== beat_data(8'hC1, idx) || data_in_tready !== rdy) begin
        n_fail++; $display("FAIL bp beat %0d: got tvalid=%b data=%h tready=%b want 0010/%h/%b", idx, data_out_tvalid, data_out_tdata[1], data_in_tready, beat_data(8'hC1, idx), rdy);
      end
      if (rdy) idx++;
      cycles++;
      tick();
    end
    data_in_tvalid = 1'b0;
    data_out_tready = 4'hF;
    n_checks++; if (idx != 10) begin n_fail++; $display("FAIL bp_timeout: got %0d beats want 10", idx); end
    n_checks++; if (fwd_count !== 32'd5) begin n_fail++; $display("FAIL bp_count: got %0d want 5", fwd_count); end
    tick();
  endtask

  task automatic test_overflow();
    for (int k = 0; k < 8; k++) send_meta(1'b1, 4'd0);
    n_checks++; if (meta_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_at_full: got %b want 0", meta_overflow); end
    send_meta(1'b1, 4'd0);
    n_checks++; if (meta_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_ninth: got %b want 1", meta_overflow); end
    rst = 1'b1; tick(); rst = 1'b0; tick();
    for (int k = 0; k < 8; k++) send_meta(1'b1, 4'd0);
    set_beat(8'hF0, 0, 1);
    tick();
    meta_in       = {14'h0, 4'd0, 1'b1};
    meta_in_valid = 1'b1;
    tick();
    meta_in_valid = 1'b0;
    data_in_tvalid = 1'b0;
    n_checks++; if (meta_overflow !== 1'b0 || drop_count !== 32'd1) begin n_fail++; $display("FAIL ovf_push_pop: got ovf=%b drop=%0d want 0/1", meta_overflow, drop_count); end
    // FIFO should still hold 8 entries: drain with continuous single-beat packets.
    set_beat(8'hF1, 0, 1);
    for (int c = 0; c < 20; c++) tick();
    #1;
    n_checks++; if (drop_count !== 32'd9 || data_in_tready !== 1'b0) begin n_fail++; $display("FAIL ovf_drain: got drop=%0d tready=%b want 9/0", drop_count, data_in_tready); end
    data_in_tvalid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_packet();
    send_meta(1'b0, 4'd3);
    set_beat(8'h55, 0, 5);
    tick();
    tick();
    set_beat(8'h55, 1, 5);
    #1;
    n_checks++; if (data_out_tvalid !== 4'b1000) begin n_fail++; $display("FAIL rstmid_pre: got %b want 1000", data_out_tvalid); end
    rst = 1'b1;
    #1;
    n_checks++; if (data_out_tvalid !== 4'b0 || data_in_tready !== 1'b0) begin n_fail++; $display("FAIL rstmid_outputs: got tvalid=%b tready=%b want 0000/0", data_out_tvalid, data_in_tready); end
    n_checks++; if (drop_count !== 32'd0 || fwd_count !== 32'd0 || meta_overflow !== 1'b0) begin n_fail++; $display("FAIL rstmid_counts: got drop=%0d fwd=%0d ovf=%b want 0/0/0", drop_count, fwd_count, meta_overflow); end
    tick();
    rst = 1'b0;
    data_in_tvalid = 1'b0;
    tick();
    // Data arrives first; metadata follows one cycle later.
    set_beat(8'h66, 0, 1);
    tick();
    n_checks++; if (data_in_tready !== 1'b0 || data_out_tvalid !== 4'b0) begin n_fail++; $display("FAIL late_meta_wait: got tready=%b tvalid=%b want 0/0000", data_in_tready, data_out_tvalid); end
    send_meta(1'b0, 4'd0);
    n_checks++; if (data_out_tvalid !== 4'b0) begin n_fail++; $display("FAIL late_meta_idle: got %b want 0000", data_out_tvalid); end
    tick();
    n_checks++; if (data_out_tvalid !== 4'b0001 || data_out_tdata[0] !== beat_data(8'h66, 0) || data_out_tlast[0] !== 1'b1) begin
      n_fail++; $display("FAIL late_meta_route: got tvalid=%b data=%h last=%b want 0001/%h/1", data_out_tvalid, data_out_tdata[0], data_out_tlast[0], beat_data(8'h66, 0));
    end
    tick();
    data_in_tvalid = 1'b0;
    n_checks++; if (fwd_count !== 32'd1) begin n_fail++; $display("FAIL late_meta_count: got %0d want 1", fwd_count); end
    tick();
  endtask

  initial begin
    test_reset();
    test_forward();
    test_drop();
    test_back_to_back();
    test_backpressure();
    test_overflow();
    test_reset_mid_packet();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/p4_egress_demux.md
# p4_egress_demux

Downstream stage of the P4 router: consumes the Vitis Net P4 output packet stream and its 19-bit user metadata, then steers each packet to one of `NUM_PORTS` egress AXI-Stream ports or drops it. Metadata arrives as a single-cycle pulse per packet with no backpressure, so it is queued in a small FIFO and paired in order with packets on the data stream. Sits between the P4 router and the per-port egress queues.

## Interface
- `NUM_PORTS`, default 4: number of egress ports; 2..16.
- `DATA_BYTES`, default 8: AXIS data width in bytes; must equal the router's `VNP4_DATA_BYTES`.
- `META_FIFO_DEPTH`, default 8: metadata FIFO entries; power of two, ≥ 2.
- `clk_ifc` (`Clock_int.Input`), 1 bit: single clock for the whole block.
- `areset_ifc` (`Reset_int.ResetIn`), 1 bit: asynchronous, active-high reset.
- `meta_in`, in, 19 bits: router `user_metadata_out`.
- `meta_in_valid`, in, 1 bit: router `user_metadata_out_valid`; one pulse per packet.
- `data_in` (`AXIS_int.Slave`), `DATA_BYTES*8` bits: router `m_axis` stream (tdata/tkeep/tlast/tvalid/tready).
- `data_out[NUM_PORTS]` (`AXIS_int.Master`), `DATA_BYTES*8` bits each: egress streams.
- `drop_count`, out, 32 bits: packets dropped; saturates at 0xFFFF_FFFF.
- `fwd_count`, out, 32 bits: packets forwarded; saturates at 0xFFFF_FFFF.
- `meta_overflow`, out, 1 bit: sticky; set when metadata arrives while the FIFO is full and is not popped that cycle. Cleared only by reset.

## Operation
- Metadata fields (package constants): bit 0 `drop`, bits 4:1 `egress_port`, bits 18:5 reserved (ignored).
- Metadata FIFO: written on every `meta_in_valid`. On overflow, the entry is discarded and `meta_overflow` is set. Pairing after an overflow is undefined; software must reset the block.
- FSM states:
  - `IDLE`: `data_in.tready`=0 and all `data_out` tvalid=0. When the FIFO is non-empty and `data_in.tvalid`=1, latch the head entry. Go to `DROP` if `drop`=1 or `egress_port` ≥ `NUM_PORTS`; otherwise go to `FWD` with `sel`=`egress_port`.
  - `FWD`: `data_out[sel]` carries `data_in` tdata/tkeep/tlast/tvalid combinationally, and `data_in.tready` = `data_out[sel].tready`. All other ports have tvalid=0. When a beat transfers with tlast=1: pop the FIFO, increment `fwd_count`, go to `IDLE`.
  - `DROP`: `data_in.tready`=1 and no output tvalid. When a beat with tlast=1 is accepted: pop the FIFO, increment `drop_count`, go to `IDLE`.
- Reset values: FSM `IDLE`; FIFO empty; all tvalid=0; `data_in.tready`=0; counters 0; `meta_overflow`=0.
- Reset mid-packet: everything returns to reset values immediately (asynchronous). The downstream port sees a truncated packet with no tlast, and the egress queues tolerate this.

## Timing
- A FIFO write is visible (non-empty) on the cycle after `meta_in_valid`.
- The `IDLE` decision takes 1 cycle. The first beat can transfer on the cycle after both the metadata and `data_in.tvalid` are present. There is one idle cycle between consecutive packets.
- In `FWD`, data path latency is 0 cycles (combinational pass-through). tvalid, tdata, tkeep and tlast are held while tready=0 per AXIS rules.
- Metadata may precede its packet's first beat by any number of cycles, or arrive up to 1 cycle after it. The packet waits in `IDLE` with tready=0 until its metadata arrives.
- Simultaneous push and pop on a full FIFO: legal and not an overflow. Occupancy stays full.
- Single-beat packets (tlast on the first beat) are legal in both `FWD` and `DROP`.
- Counters update on the cycle after the tlast transfer.

## Structure
- `p4_router_pkg`:
  - `META_WIDTH`=19, `META_DROP_BIT`=0, `META_PORT_LSB`=1, `META_PORT_W`=4.
  - Typedef `p4_meta_t` (packed struct).
  - FSM state enum `egress_state_t`.
- Sub-module `p4_meta_fifo`: single-clock register FIFO with `full`/`empty`, simultaneous push/pop, and asynchronous reset.
- Top level contains the FSM, the output mux/demux and the counters.

## Test plan
- Metadata `drop`=0, `egress_port`=2, then a 4-beat packet: beats appear only on `data_out[2]` with tkeep/tlast intact, `fwd_count`=1, FIFO empty afterwards.
- Metadata `drop`=1, 3-beat packet: `data_in.tready`=1 for all beats, no output tvalid, `drop_count`=1. Repeat with `egress_port`=7 and `NUM_PORTS`=4: also dropped, `drop_count`=2.
- Three metadata pulses (ports 0, 1, 3) issued back-to-back before any data, then three packets: each packet goes to its port in order, with a 1-cycle gap between packets.
- Random tready backpressure on `data_out[1]` during a 10-beat packet: no beat lost or duplicated, and tdata is stable while stalled.
- Push 9 metadata pulses into an 8-deep FIFO with no data: `meta_overflow`=1 from the cycle after the 9th pulse. Repeat the push with a simultaneous tlast pop at full: `meta_overflow` stays 0.
- Assert reset during beat 2 of a 5-beat packet: all outputs return to reset values within the reset cycle, counters read 0, and the next packet after release is routed correctly.
